pwm_multi: RTL and testbench
============================

Name: pwm_multi

Overview:
- Multi-channel, width-parametrised PWM generator; successor to the single-channel 8-bit PWM.
- One shared period counter drives CHANNELS compare outputs.
- Period and duty are double-buffered: shadow registers reload only at period boundaries, so mid-period writes cause no glitches.
- A one-cycle wrap pulse marks each boundary, so downstream logic (ADC triggers, sequencers) can sync to the PWM frame.

Parameters:
- WIDTH, 8: bit width of counter, period and each duty value.
- CHANNELS, 4: number of independent compare outputs sharing the counter.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- io_en  input  1  global enable.
- io_periodCounter  input  WIDTH  requested period, in counter steps.
- io_dutyCicle  input  CHANNELS*WIDTH  requested duty per channel; channel i occupies bits [i*WIDTH +: WIDTH].
- io_chEn  input  CHANNELS  per-channel output enable mask.
- io_out  output  CHANNELS  PWM outputs.
- io_contador  output  WIDTH  current counter value.
- io_wrap  output  1  one-cycle pulse on the last cycle of each period.

Behaviour:
- Reset (any cycle, including mid-period) sets, at the next edge:
  - cnt = 0
  - per_act = 0
  - all duty_act = 0
  - io_out = 0, io_wrap = 0
- Reset has priority over every other event.
- Idle (io_en = 0, or per_act = 0):
  - cnt = 0.
  - per_act and duty_act reload from the inputs every cycle, so the first period after enable uses the values present on the enabling edge.
- Run (io_en = 1, per_act ≥ 1), edge-aligned counter sequence: 1, 2, …, per_act, then 1, …
  - cnt moves from 0 to 1 on the first enabled edge.
  - cnt never exceeds per_act.
- io_wrap = io_en && per_act != 0 && cnt == per_act.
  - Combinational from registered state.
  - On the edge that follows an io_wrap cycle, per_act and duty_act reload from the inputs and cnt becomes 1.
  - Input changes at any other time have no effect until the next wrap.
- io_out[i] = io_en && io_chEn[i] && cnt != 0 && cnt <= duty_act[i].
  - Combinational from registered cnt/duty_act, so zero latency relative to io_contador.
  - io_en and io_chEn gate the output in the same cycle they drop.
- Duty boundaries:
  - duty_act = 0: output constantly low.
  - duty_act ≥ per_act: output constantly high while running (100%); there is no wrap glitch.
  - per_act = 1: cnt stays at 1; io_wrap is high every cycle.
- io_en dropping mid-period: outputs go low in that same cycle; cnt = 0 at the next edge; the restart begins a fresh period.
- io_contador = cnt; all arithmetic is unsigned WIDTH-bit; the counter never overflows because it is bounded by per_act.

Optional Feature:
- Macro: PWM_CENTER_ALIGN_EN.
- With the macro:
  - Adds input io_center (1 bit), sampled into the shadow set like the period.
  - When the active center bit = 1, the counter runs as a triangle: 1, 2, …, per_act, per_act-1, …, 2, then 1, … (a 2*per_act-2 cycle period for per_act ≥ 2).
  - An internal direction flag is cleared by reset and while idle.
  - io_wrap is high on the down-count cycle where cnt == 2; reload happens on the following edge, at the valley.
  - per_act = 1 behaves exactly as in edge mode.
  - The io_out compare rule is unchanged, giving a pulse centred on the valley.
- Without the macro: no io_center port; edge-aligned counting only.

Test Plan:
- Reset, then period = 5, duty = {0, 2, 5, 7}, chEn = 4'hF, en = 1.
  - io_contador follows 1,2,3,4,5,1.
  - ch0 always 0.
  - ch1 high at cnt 1–2.
  - ch2 and ch3 high for the entire period.
  - io_wrap high only at cnt = 5.
- Running with period 5: change period to 3 and duty1 to 1 at cnt = 2.
  - Cycles through cnt = 5 keep the old waveform.
  - From the wrap onward: cnt 1,2,3, and ch1 is high only at cnt = 1.
- Drop en at cnt = 3 with ch1 high.
  - io_out = 0 in the same cycle.
  - cnt = 0 at the next edge.
  - Re-enable: cnt restarts at 1.
- Assert reset at cnt = 4 with en held high.
  - Next edge: cnt = 0, io_out = 0.
  - After reset releases: cnt = 1 on the first enabled edge.
- Period = 1, duty0 = 1 → cnt stuck at 1, ch0 constantly high, io_wrap constantly high. Period = 0 → cnt = 0, all outputs low.
- PWM_CENTER_ALIGN_EN build, center = 1, period = 4, duty = 2 → cnt 1,2,3,4,3,2,1,2…; out high at cnt ≤ 2; io_wrap on the down-count cnt = 2 cycle.

Source files
------------

// File: rtl/pwm_multi.sv
// ============================================================================
// Module   : pwm_multi
// Purpose  : Multi-channel PWM generator. One shared period counter drives
//            CHANNELS compare outputs. Period and duty values are
//            double-buffered and reload only at frame boundaries. A one-cycle
//            wrap pulse marks the last cycle of each frame.
// Options  : Define PWM_CENTER_ALIGN_EN to add the io_center input, which
//            selects triangle (center-aligned) counting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      io_en,
  input  logic [WIDTH-1:0]          io_periodCounter,
  input  logic [CHANNELS*WIDTH-1:0] io_dutyCicle,
  input  logic [CHANNELS-1:0]       io_chEn,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic                      io_center,
`endif
  output logic [CHANNELS-1:0]       io_out,
  output logic [WIDTH-1:0]          io_contador,
  output logic                      io_wrap
);

  localparam logic [WIDTH-1:0] c_ZERO = '0;
  localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_TWO  = WIDTH'(2);

  // Active (shadow) state
  logic [WIDTH-1:0]          r_cnt;
  logic [WIDTH-1:0]          r_per;
  logic [CHANNELS*WIDTH-1:0] r_duty;

  // Next-state values
  logic [WIDTH-1:0]          w_cnt_nxt;
  logic [WIDTH-1:0]          w_per_nxt;
  logic [CHANNELS*WIDTH-1:0] w_duty_nxt;

  logic w_running;
  logic w_at_end;
  logic w_reload;

`ifdef PWM_CENTER_ALIGN_EN
  logic r_center;
  logic r_dir;        // 1 = counting down in triangle mode
  logic w_center_nxt;
  logic w_dir_nxt;
  logic w_tri;        // triangle counting active for this frame
  assign w_tri = r_center && (r_per >= c_TWO);
`endif

  assign w_running = io_en && (r_per != c_ZERO);

  // Frame end: top of the ramp in edge mode, down-count cnt==2 in triangle
  // mode (for per_act==2 the peak is also the down-count 2).
  always_comb begin
    w_at_end = (r_cnt == r_per);
`ifdef PWM_CENTER_ALIGN_EN
    if (w_tri) begin
      w_at_end = (r_cnt == c_TWO) && (r_dir || (r_per == c_TWO));
    end
`endif
  end

  assign w_reload = w_running && ((r_cnt == c_ZERO) || w_at_end);

  // Next-state: idle tracks inputs, boundaries reload shadows, else count
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_per_nxt  = r_per;
    w_duty_nxt = r_duty;
`ifdef PWM_CENTER_ALIGN_EN
    w_center_nxt = r_center;
    w_dir_nxt    = r_dir;
`endif
    if (!w_running || w_reload) begin
      w_per_nxt  = io_periodCounter;
      w_duty_nxt = io_dutyCicle;
`ifdef PWM_CENTER_ALIGN_EN
      w_center_nxt = io_center;
      w_dir_nxt    = 1'b0;
`endif
      // A new period of zero means the next frame is idle: keep cnt at 0 so
      // no channel sees a spurious compare hit.
      if (w_running && (io_periodCounter != c_ZERO)) begin
        w_cnt_nxt = c_ONE;
      end else begin
        w_cnt_nxt = c_ZERO;
      end
    end else begin
`ifdef PWM_CENTER_ALIGN_EN
      if (w_tri && r_dir) begin
        w_cnt_nxt = r_cnt - c_ONE;
      end else if (w_tri && (r_cnt == r_per)) begin
        w_dir_nxt = 1'b1;
        w_cnt_nxt = r_cnt - c_ONE;
      end else begin
        w_cnt_nxt = r_cnt + c_ONE;
      end
`else
      w_cnt_nxt = r_cnt + c_ONE;
`endif
    end
  end

  // State register with synchronous reset taking priority
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt  <= c_ZERO;
      r_per  <= c_ZERO;
      r_duty <= '0;
`ifdef PWM_CENTER_ALIGN_EN
      r_center <= 1'b0;
      r_dir    <= 1'b0;
`endif
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_per  <= w_per_nxt;
      r_duty <= w_duty_nxt;
`ifdef PWM_CENTER_ALIGN_EN
      r_center <= w_center_nxt;
      r_dir    <= w_dir_nxt;
`endif
    end
  end

  assign io_contador = r_cnt;
  assign io_wrap     = w_running && w_at_end;

  // Per-channel compare, gated combinationally by the enables
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign io_out[gi] = io_en && io_chEn[gi] && (r_cnt != c_ZERO) &&
                          (r_cnt <= r_duty[gi*WIDTH +: WIDTH]);
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pwm_multi.sv
// ============================================================================
// Module   : tb_pwm_multi
// Purpose  : Directed self-checking bench for pwm_multi (WIDTH=8, CHANNELS=4).
//            Center-aligned scenario runs when PWM_CENTER_ALIGN_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_multi;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_en;
  logic [7:0]  io_periodCounter;
  logic [31:0] io_dutyCicle;
  logic [3:0]  io_chEn;
`ifdef PWM_CENTER_ALIGN_EN
  logic        io_center;
`endif
  logic [3:0]  io_out;
  logic [7:0]  io_contador;
  logic        io_wrap;

  int checks   = 0;
  int failures = 0;

  pwm_multi #(.WIDTH(8), .CHANNELS(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .io_en            (io_en),
    .io_periodCounter (io_periodCounter),
    .io_dutyCicle     (io_dutyCicle),
    .io_chEn          (io_chEn),
`ifdef PWM_CENTER_ALIGN_EN
    .io_center        (io_center),
`endif
    .io_out           (io_out),
    .io_contador      (io_contador),
    .io_wrap          (io_wrap)
  );

  always #5 clock = ~clock;

  // Advance one clock; sample 1 ns after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; io_en = 1'b0; io_periodCounter = 8'd0;
    io_dutyCicle = 32'd0; io_chEn = 4'h0;
`ifdef PWM_CENTER_ALIGN_EN
    io_center = 1'b0;
`endif
    tick(); tick();
    checks++;
    if (io_contador !== 8'd0 || io_out !== 4'b0000 || io_wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: cnt=%0d out=%b wrap=%b required cnt=0 out=0000 wrap=0",
               io_contador, io_out, io_wrap);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] exp_cnt [6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd1};
    logic [3:0] exp_out [6] = '{4'b1110, 4'b1110, 4'b1100, 4'b1100, 4'b1100, 4'b1110};
    logic       exp_wrp [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bit seen = 1'b0;
    io_periodCounter = 8'd5;
    io_dutyCicle = {8'd7, 8'd5, 8'd2, 8'd0};
    io_chEn = 4'hF;
    io_en = 1'b1;
    for (int k = 0; k < 4 && !seen; k++) begin
      tick();
      if (io_contador == 8'd1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL basic_start: cnt=%0d required 1 within 4 cycles", io_contador);
    end
    for (int i = 0; i < 6; i++) begin
      if (i != 0) tick();
      checks++;
      if (io_contador !== exp_cnt[i] || io_out !== exp_out[i] || io_wrap !== exp_wrp[i]) begin
        failures++;
        $display("FAIL basic[%0d]: cnt=%0d out=%b wrap=%b required cnt=%0d out=%b wrap=%b",
                 i, io_contador, io_out, io_wrap, exp_cnt[i], exp_out[i], exp_wrp[i]);
      end
    end
  endtask

  task automatic test_reload();
    logic [7:0] exp_cnt [8] = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd1, 8'd2, 8'd3, 8'd1};
    logic [3:0] exp_out [8] = '{4'b1110, 4'b1100, 4'b1100, 4'b1100,
                                4'b1110, 4'b1100, 4'b1100, 4'b1110};
    logic       exp_wrp [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tick();
    io_periodCounter = 8'd3;
    io_dutyCicle = {8'd7, 8'd5, 8'd1, 8'd0};
    #1;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) tick();
      checks++;
      if (io_contador !== exp_cnt[i] || io_out !== exp_out[i] || io_wrap !== exp_wrp[i]) begin
        failures++;
        $display("FAIL reload[%0d]: cnt=%0d out=%b wrap=%b required cnt=%0d out=%b wrap=%b",
                 i, io_contador, io_out, io_wrap, exp_cnt[i], exp_out[i], exp_wrp[i]);
      end
    end
  endtask

  task automatic test_en_drop();
    io_dutyCicle = {8'd7, 8'd5, 8'd3, 8'd0};
    tick(); tick(); tick(); tick(); tick();
    checks++;
    if (io_contador !== 8'd3 || io_out !== 4'b1110) begin
      failures++;
      $display("FAIL en_pre: cnt=%0d out=%b required cnt=3 out=1110", io_contador, io_out);
    end
    io_en = 1'b0;
    #1;
    checks++;
    if (io_out !== 4'b0000 || io_wrap !== 1'b0) begin
      failures++;
      $display("FAIL en_drop_same_cycle: out=%b wrap=%b required out=0000 wrap=0", io_out, io_wrap);
    end
    tick();
    checks++;
    if (io_contador !== 8'd0) begin
      failures++;
      $display("FAIL en_drop_cnt: cnt=%0d required 0", io_contador);
    end
    io_en = 1'b1;
    tick();
    checks++;
    if (io_contador !== 8'd1 || io_out !== 4'b1110) begin
      failures++;
      $display("FAIL en_restart: cnt=%0d out=%b required cnt=1 out=1110", io_contador, io_out);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    bit bad_prev = 1'b0;
    logic [7:0] prev;
    io_periodCounter = 8'd5;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (io_contador == 8'd4) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL reset_mid_reach4: cnt=%0d required 4 within 20 cycles", io_contador);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (io_contador !== 8'd0 || io_out !== 4'b0000 || io_wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: cnt=%0d out=%b wrap=%b required cnt=0 out=0000 wrap=0",
               io_contador, io_out, io_wrap);
    end
    reset = 1'b0;
    seen = 1'b0;
    prev = io_contador;
    for (int k = 0; k < 3 && !seen; k++) begin
      tick();
      if (io_contador == 8'd1) begin
        seen = 1'b1;
        if (prev !== 8'd0) bad_prev = 1'b1;
      end
      prev = io_contador;
    end
    checks++;
    if (!seen || bad_prev) begin
      failures++;
      $display("FAIL reset_restart: cnt=%0d required 1 (from 0) within 3 cycles", io_contador);
    end
  endtask

  task automatic test_period_one();
    io_en = 1'b0;
    io_periodCounter = 8'd1;
    io_dutyCicle = {8'd0, 8'd0, 8'd0, 8'd1};
    tick();
    io_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (io_contador !== 8'd1 || io_out !== 4'b0001 || io_wrap !== 1'b1) begin
        failures++;
        $display("FAIL period_one[%0d]: cnt=%0d out=%b wrap=%b required cnt=1 out=0001 wrap=1",
                 i, io_contador, io_out, io_wrap);
      end
    end
    io_periodCounter = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (io_contador !== 8'd0 || io_out !== 4'b0000 || io_wrap !== 1'b0) begin
        failures++;
        $display("FAIL period_zero[%0d]: cnt=%0d out=%b wrap=%b required cnt=0 out=0000 wrap=0",
                 i, io_contador, io_out, io_wrap);
      end
    end
  endtask

`ifdef PWM_CENTER_ALIGN_EN
  task automatic test_center();
    logic [7:0] exp_cnt [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1, 8'd2};
    logic [3:0] exp_out [8] = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF};
    logic       exp_wrp [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    io_en = 1'b0;
    io_center = 1'b1;
    io_periodCounter = 8'd4;
    io_dutyCicle = {8'd2, 8'd2, 8'd2, 8'd2};
    tick();
    io_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (io_contador !== exp_cnt[i] || io_out !== exp_out[i] || io_wrap !== exp_wrp[i]) begin
        failures++;
        $display("FAIL center[%0d]: cnt=%0d out=%b wrap=%b required cnt=%0d out=%b wrap=%b",
                 i, io_contador, io_out, io_wrap, exp_cnt[i], exp_out[i], exp_wrp[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_reload();
    test_en_drop();
    test_reset_mid();
    test_period_one();
`ifdef PWM_CENTER_ALIGN_EN
    test_center();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
